// File: rtl/nts_pkg.sv
// nts_pkg: shared FSM encodings and defaults for the nonce generator arbiter.
package nts_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nts_rr_arbiter.sv
// nts_rr_arbiter: picks the first pending engine at or after the start index.
module nts_rr_arbiter
    import nts_pkg::*;
#(
    parameter int ENGINES = 4,
    localparam int IW = idx_w(ENGINES)
) (
    input  logic [ENGINES-1:0] pending,
    input  logic [IW-1:0]      ptr,
    output logic [ENGINES-1:0] grant,
    output logic [IW-1:0]      index,
    output logic               found
);

    logic [IW:0] k;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < ENGINES; i++) begin
            k = {1'b0, ptr} + (IW+1)'(i);
            if (k >= (IW+1)'(ENGINES)) begin
                k = k - (IW+1)'(ENGINES);
            end
            if (!found && pending[k[IW-1:0]]) begin
                found = 1'b1;
                index = k[IW-1:0];
            end
        end
        if (found) begin
            grant[index] = 1'b1;
        end
    end

endmodule

// File: rtl/nts_noncegen_arbiter.sv
// nts_noncegen_arbiter: shares one nonce generator among several engines.
// Define NTS_NONCEGEN_TIMEOUT_EN to enable the generator timeout/reissue.
module nts_noncegen_arbiter
    import nts_pkg::*;
#(
    parameter int ENGINES        = 4,
    parameter int NONCE_WIDTH    = 64,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_areset,
    input  logic [ENGINES-1:0]     i_engine_get,
    output logic [ENGINES-1:0]     o_engine_ready,
    output logic [NONCE_WIDTH-1:0] o_engine_data,
    output logic                   o_noncegen_get,
    input  logic                   i_noncegen_ready,
    input  logic [NONCE_WIDTH-1:0] i_noncegen_data,
    output logic                   o_busy,
    output logic                   o_timeout
);

    localparam int IW = idx_w(ENGINES);

    state_t                 state;
    logic [ENGINES-1:0]     pending;
    logic [ENGINES-1:0]     grant;
    logic [ENGINES-1:0]     deliver;
    logic [ENGINES-1:0]     rr_grant;
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          next_ptr;
    logic [IW-1:0]          rr_index;
    logic                   rr_found;
    logic [NONCE_WIDTH-1:0] data;
    logic                   expired;

    nts_rr_arbiter #(
        .ENGINES(ENGINES)
    ) u_rr (
        .pending(pending),
        .ptr    (ptr),
        .grant  (rr_grant),
        .index  (rr_index),
        .found  (rr_found)
    );

    assign next_ptr = (rr_index == IW'(ENGINES - 1)) ? '0 : rr_index + 1'b1;
    assign deliver  = (state == ST_DELIVER) ? grant : '0;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state   <= ST_IDLE;
            pending <= '0;
            grant   <= '0;
            ptr     <= '0;
            data    <= '0;
        end else begin
            // A get arriving during its own delivery survives as a new request.
            pending <= (pending & ~deliver) | i_engine_get;
            unique case (state)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant <= rr_grant;
                        ptr   <= next_ptr;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_noncegen_ready) begin
                        data  <= i_noncegen_data;
                        state <= ST_DELIVER;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_noncegen_ready) begin
                        data  <= i_noncegen_data;
                        state <= ST_DELIVER;
                    end else if (expired) begin
                        state <= ST_REQ;
                    end
                end
                ST_DELIVER: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

`ifdef NTS_NONCEGEN_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          timeout_q;

    assign expired = (state == ST_WAIT) && !i_noncegen_ready
                     && (wait_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expired;
            if (state != ST_WAIT) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    assign expired   = 1'b0;
    // Always false: the parameter has no effect in this build.
    assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign o_engine_ready = deliver;
    assign o_engine_data  = data;
    assign o_noncegen_get = (state == ST_REQ);
    assign o_busy         = (state != ST_IDLE) || (|pending);

endmodule

// File: tb/tb_nts_noncegen_arbiter.sv
// tb_nts_noncegen_arbiter: vectors, corner sequences and a random run
// against a transaction-level round-robin model.
module tb_nts_noncegen_arbiter;

    localparam int E = 4;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [E-1:0] eget, erdy;
    logic [W-1:0] edata, ndata;
    logic         ngget, nrdy, busy, tout;
    logic [E-1:0] t_eget, t_erdy;
    logic [W-1:0] t_edata, t_ndata;
    logic         t_ngget, t_nrdy, t_busy, t_tout;

    always #5 clk = ~clk;

    nts_noncegen_arbiter #(.ENGINES(E), .NONCE_WIDTH(W)) dut (
        .i_clk(clk), .i_areset(rst),
        .i_engine_get(eget), .o_engine_ready(erdy), .o_engine_data(edata),
        .o_noncegen_get(ngget), .i_noncegen_ready(nrdy),
        .i_noncegen_data(ndata), .o_busy(busy), .o_timeout(tout)
    );

    nts_noncegen_arbiter #(.ENGINES(E), .NONCE_WIDTH(W),
                           .TIMEOUT_CYCLES(8)) dut_to (
        .i_clk(clk), .i_areset(rst),
        .i_engine_get(t_eget), .o_engine_ready(t_erdy),
        .o_engine_data(t_edata), .o_noncegen_get(t_ngget),
        .i_noncegen_ready(t_nrdy), .i_noncegen_data(t_ndata),
        .o_busy(t_busy), .o_timeout(t_tout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         c;
        logic [3:0] r;
        logic [63:0] d;
    } dlv_t;

    dlv_t        dq[$];
    int          gq[$];
    int          tgq[$];
    int          ttq[$];
    bit          t_idle_seen;
    bit          t_dlv_seen;
    int          cyc;
    int          t0;
    int          gen_due;
    logic [63:0] gen_n;
    bit          inject;

    bit          mdl_en;
    logic [3:0]  m1, m2;
    int          rr_next;
    int          exp_g[$];
    logic [63:0] exp_d[$];
    int          rnd_dlv;

    function automatic int rr_pick(input logic [3:0] p, input int start);
        for (int k = 0; k < E; k++) begin
            if (p[(start + k) % E]) return (start + k) % E;
        end
        return -1;
    endfunction

    task automatic start();
        t0 = cyc + 1;
        dq.delete();
        gq.delete();
        tgq.delete();
        ttq.delete();
        t_idle_seen = 0;
        t_dlv_seen = 0;
    endtask

    task automatic step(input logic [3:0] g, input logic [3:0] tg);
        logic [3:0] nm;
        int         pk;
        int         dg;
        @(posedge clk);
        #1;
        cyc++;
        eget = g;
        t_eget = tg;
        nrdy = inject;
        inject = 0;
        if (cyc == gen_due) begin
            nrdy = 1'b1;
            gen_n++;
            ndata = gen_n;
            if (mdl_en) exp_d.push_back(gen_n);
        end
        @(negedge clk);
        chk("onehot", 64'($onehot0(erdy)), 64'd1);
        dg = -1;
        if (ngget) begin
            gq.push_back(cyc - t0);
            gen_due = cyc + (mdl_en ? int'($urandom_range(1, 6)) : 16);
            if (mdl_en) begin
                pk = rr_pick(m2, rr_next);
                chk("rnd_arb_has_req", 64'(pk >= 0), 64'd1);
                if (pk >= 0) begin
                    exp_g.push_back(pk);
                    rr_next = (pk + 1) % E;
                end
            end
        end
        if (|erdy) begin
            dq.push_back('{cyc - t0, erdy, edata});
            if (mdl_en) begin
                rnd_dlv++;
                if (exp_g.size() == 0 || exp_d.size() == 0) begin
                    chk("rnd_unexpected_dlv", 64'(erdy), 64'd0);
                end else begin
                    dg = exp_g.pop_front();
                    chk("rnd_grant", 64'(erdy), 64'(4'b0001 << dg));
                    chk("rnd_data", edata, exp_d.pop_front());
                end
            end
        end
        if (mdl_en) begin
            nm = m1;
            if (dg >= 0) nm[dg] = 1'b0;
            nm = nm | eget;
            m2 = m1;
            m1 = nm;
        end
        if (t_ngget) tgq.push_back(cyc - t0);
        if (t_tout) ttq.push_back(cyc - t0);
        if (|t_erdy) t_dlv_seen = 1;
        if (!t_busy && (cyc - t0) >= 1) t_idle_seen = 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        eget = '0;
        t_eget = '0;
        nrdy = 1'b0;
        gen_due = -1;
        gen_n = '0;
        mdl_en = 0;
        @(negedge clk);
        chk("rst_ready", 64'(erdy), 64'd0);
        chk("rst_data", edata, 64'd0);
        chk("rst_ngget", 64'(ngget), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tout", 64'(tout | t_tout), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_idle(input int min_rel, input int max_cyc);
        bit done;
        done = 0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            step(4'b0000, 4'b0000);
            done = ((cyc - t0) >= min_rel) && !busy;
        end
        chk("idle_reached", 64'(done), 64'd1);
    endtask

    typedef struct {
        logic [3:0] get;
        logic [3:0] first;
        int         ndlv;
    } vec_t;

    vec_t vt[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        eget = '0;
        t_eget = '0;
        nrdy = 1'b0;
        ndata = '0;
        t_nrdy = 1'b0;
        t_ndata = '0;
        inject = 0;
        cyc = 0;
        gen_due = -1;
        gen_n = '0;
        mdl_en = 0;
        rnd_dlv = 0;

        vt[0] = '{4'b0001, 4'b0001, 1};
        vt[1] = '{4'b0100, 4'b0100, 1};
        vt[2] = '{4'b1000, 4'b1000, 1};
        vt[3] = '{4'b0110, 4'b0010, 2};
        vt[4] = '{4'b1010, 4'b0010, 2};
        vt[5] = '{4'b1001, 4'b0001, 2};
        vt[6] = '{4'b1111, 4'b0001, 4};

        // Single-shot vectors from a fresh reset.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            start();
            step(vt[v].get, 4'b0000);
            step(4'b0000, 4'b0000);
            chk("vec_busy", 64'(busy), 64'd1);
            run_idle(20, 200);
            chk("vec_ndlv", 64'(dq.size()), 64'(vt[v].ndlv));
            chk("vec_ngcnt", 64'(gq.size()), 64'(vt[v].ndlv));
            if (gq.size() > 0) chk("vec_get_cyc", 64'(gq[0]), 64'd2);
            if (dq.size() > 0) begin
                chk("vec_dlv_cyc", 64'(dq[0].c), 64'd19);
                chk("vec_dlv_rdy", 64'(dq[0].r), 64'(vt[v].first));
                chk("vec_dlv_data", dq[0].d, 64'd1);
            end
        end

        // Fairness: all four at once.
        do_reset();
        start();
        step(4'b1111, 4'b0000);
        run_idle(20, 200);
        chk("fair_n", 64'(dq.size()), 64'd4);
        for (int i = 0; i < 4 && i < dq.size(); i++) begin
            chk("fair_rdy", 64'(dq[i].r), 64'(4'b0001 << i));
            chk("fair_data", dq[i].d, 64'(i + 1));
            chk("fair_cyc", 64'(dq[i].c), 64'(19 + 19 * i));
        end

        // Duplicate get before delivery: one delivery.
        do_reset();
        start();
        step(4'b0100, 4'b0000);
        for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000);
        step(4'b0100, 4'b0000);
        run_idle(20, 200);
        chk("dup_n", 64'(dq.size()), 64'd1);

        // Re-request during own DELIVER: second delivery follows.
        do_reset();
        start();
        step(4'b0100, 4'b0000);
        for (int i = 1; i < 19; i++) step(4'b0000, 4'b0000);
        step(4'b0100, 4'b0000);
        chk("rereq_rdy_now", 64'(erdy), 64'(4'b0100));
        for (int i = 0; i < 6; i++) step(4'b0000, 4'b0000);
        chk("rereq_hold_data", edata, 64'd1);
        chk("rereq_busy", 64'(busy), 64'd1);
        run_idle(20, 200);
        chk("rereq_n", 64'(dq.size()), 64'd2);
        if (dq.size() > 1) begin
            chk("rereq_cyc", 64'(dq[1].c), 64'd38);
            chk("rereq_r", 64'(dq[1].r), 64'(4'b0100));
            chk("rereq_d", dq[1].d, 64'd2);
        end

        // Stray generator ready while idle.
        do_reset();
        start();
        step(4'b0000, 4'b0000);
        inject = 1;
        for (int i = 0; i < 6; i++) step(4'b0000, 4'b0000);
        chk("stray_n", 64'(dq.size()), 64'd0);
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_ngget", 64'(gq.size()), 64'd0);

        // Reset in WAIT after one completed delivery.
        do_reset();
        start();
        step(4'b0001, 4'b0000);
        run_idle(20, 200);
        start();
        step(4'b0001, 4'b0000);
        for (int i = 1; i <= 5; i++) step(4'b0000, 4'b0000);
        chk("rstw_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstw_data", edata, 64'd0);
        chk("rstw_ready", 64'(erdy), 64'd0);
        chk("rstw_ngget", 64'(ngget), 64'd0);
        chk("rstw_busy", 64'(busy), 64'd0);
        chk("rstw_tout", 64'(tout), 64'd0);
        step(4'b0000, 4'b0000);
        rst = 1'b0;
        for (int i = 7; i <= 30; i++) step(4'b0000, 4'b0000);
        chk("rstw_n", 64'(dq.size()), 64'd0);
        chk("rstw_ngget_n", 64'(gq.size()), 64'd1);
        chk("rstw_busy_end", 64'(busy), 64'd0);
        chk("rstw_data_end", edata, 64'd0);

        // Generator that never answers (second instance).
        do_reset();
        start();
        step(4'b0000, 4'b0001);
        for (int i = 1; i <= 40; i++) step(4'b0000, 4'b0000);
        chk("to_no_dlv", 64'(t_dlv_seen), 64'd0);
`ifdef NTS_NONCEGEN_TIMEOUT_EN
        chk("to_get_n", 64'(tgq.size()), 64'd4);
        chk("to_tout_n", 64'(ttq.size()), 64'd3);
        for (int i = 0; i < 4 && i < tgq.size(); i++)
            chk("to_get_cyc", 64'(tgq[i]), 64'(2 + 10 * i));
        for (int i = 0; i < 3 && i < ttq.size(); i++)
            chk("to_tout_cyc", 64'(ttq[i]), 64'(12 + 10 * i));
`else
        chk("to_get_n", 64'(tgq.size()), 64'd1);
        chk("to_tout_n", 64'(ttq.size()), 64'd0);
`endif
        chk("to_busy_held", 64'(t_idle_seen), 64'd0);

        // Random traffic against the transaction model.
        do_reset();
        start();
        mdl_en = 1;
        m1 = '0;
        m2 = '0;
        rr_next = 0;
        exp_g.delete();
        exp_d.delete();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] g;
            for (int b = 0; b < E; b++) g[b] = ($urandom_range(0, 15) == 0);
            step(g, 4'b0000);
        end
        run_idle(0, 400);
        chk("rnd_left_grants", 64'(exp_g.size()), 64'd0);
        chk("rnd_left_pending", 64'(m1), 64'd0);
        chk("rnd_enough", 64'(rnd_dlv >= 20), 64'd1);
        mdl_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
